// File: rtl/alu_mc.sv
// Purpose : multi-cycle ALU; logic/add/sub/slt in one cycle, shift-add MUL and restoring DIVU/REMU iterate.
// Latency : result registered one cycle after acceptance, WIDTH+1 cycles for MUL and DIVU/REMU with b!=0.
// Backpressure: valid/ready both sides; result holds in DONE until out_ready, next request may be taken in that same cycle.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake carrying a, b (WIDTH) and f (4-bit opcode)
//   out_valid/out_ready - result handshake carrying y (WIDTH) and flags zero, ovf, err
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ANDN = 4'b0100;
    localparam logic [3:0] OP_ORN  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [3:0]       rf;
    // MUL: acc = partial product, opa = shifted multiplicand, opb = shifted multiplier.
    // DIV: acc = partial remainder, opa = dividend shifting out / quotient shifting in, opb = divisor.
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_nxt, opa_nxt, opb_nxt;
    logic [WIDTH:0]   rem_sh, rem_dif;
    logic [WIDTH-1:0] res_y;

    logic             accept, multi, last;

    logic [WIDTH-1:0] sum, dif;
    logic [WIDTH-1:0] sc_y;
    logic             sc_ovf, sc_err;

    // ---------------------------------------------------------------
    // Single-cycle result, computed straight from the request inputs
    // ---------------------------------------------------------------
    assign sum = a + b;
    assign dif = a - b;

    always_comb begin
        sc_y   = '0;
        sc_ovf = 1'b0;
        sc_err = 1'b0;
        case (f)
            OP_AND:  sc_y = a & b;
            OP_OR:   sc_y = a | b;
            OP_ANDN: sc_y = a & ~b;
            OP_ORN:  sc_y = a | ~b;
            OP_ADD: begin
                sc_y   = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_y   = dif;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            // Direct signed compare, so SUB overflow cannot corrupt the answer.
            OP_SLT:  sc_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            // MUL always iterates; this value is never registered.
            OP_MUL:  sc_y = '0;
            // DIVU/REMU only complete here when b is zero.
            OP_DIVU: begin
                sc_y   = '1;
                sc_err = 1'b1;
            end
            OP_REMU: begin
                sc_y   = a;
                sc_err = 1'b1;
            end
            default: sc_err = 1'b1;
        endcase
    end

    assign multi = (f == OP_MUL) || (((f == OP_DIVU) || (f == OP_REMU)) && (b != '0));

    // ---------------------------------------------------------------
    // One MUL / DIV iteration per BUSY cycle
    // ---------------------------------------------------------------
    assign rem_sh  = {acc, opa[WIDTH-1]};
    assign rem_dif = rem_sh - {1'b0, opb};

    always_comb begin
        acc_nxt = acc;
        opa_nxt = opa;
        opb_nxt = opb;
        if (rf == OP_MUL) begin
            acc_nxt = acc + (opb[0] ? opa : '0);
            opa_nxt = opa << 1;
            opb_nxt = opb >> 1;
        end else if (!rem_dif[WIDTH]) begin
            // Shifted remainder >= divisor: subtract and shift in a 1.
            acc_nxt = rem_dif[WIDTH-1:0];
            opa_nxt = {opa[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = rem_sh[WIDTH-1:0];
            opa_nxt = {opa[WIDTH-2:0], 1'b0};
        end
    end

    assign res_y = (rf == OP_DIVU) ? opa_nxt : acc_nxt;
    assign last  = (cnt == CW'(WIDTH - 1));

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            in_ready = 1'b0;
        end
        // A new request overrides the drain-to-IDLE, giving back-to-back issue.
        if (in_valid && in_ready) begin
            state_nxt = multi ? BUSY : DONE;
        end
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            y    <= '0;
            zero <= 1'b0;
            ovf  <= 1'b0;
            err  <= 1'b0;
            cnt  <= '0;
            rf   <= '0;
            acc  <= '0;
            opa  <= '0;
            opb  <= '0;
        end else if (accept) begin
            rf  <= f;
            opa <= a;
            opb <= b;
            acc <= '0;
            cnt <= '0;
            if (!multi) begin
                y    <= sc_y;
                zero <= (sc_y == '0);
                ovf  <= sc_ovf;
                err  <= sc_err;
            end
        end else if (state == BUSY) begin
            acc <= acc_nxt;
            opa <= opa_nxt;
            opb <= opb_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
                y    <= res_y;
                zero <= (res_y == '0);
                ovf  <= 1'b0;
                err  <= 1'b0;
            end
        end
    end

endmodule
